decode_issue: RTL

//  ID stage of the 5-stage MIPS core; produces every control/operand field the Execute stage consumes.

---
 rtl/mips_pkg.sv | 87 ++++++++
 rtl/control_decoder.sv | 106 ++++++++++
 rtl/decode_issue.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU opcodes, opcode/funct values, operand-B select and branch kinds.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package mips_pkg;

    // ALU opcode encoding, shared with the Execute-stage ALU
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] MUXB_REG   = 2'd0;
    localparam logic [1:0] MUXB_IMM   = 2'd1;
    localparam logic [1:0] MUXB_SHAMT = 2'd2;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;

    // Decoded control bundle for one instruction word
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [3:0]  alu_fn;
        logic [1:0]  muxb;
        logic [1:0]  branch;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        uses_rs;
        logic        uses_rt;
        logic        illegal;
    } ctrl_t;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  muxb;
        logic [3:0]  alu_fn;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  branch;
    } idex_t;

endpackage

// File: rtl/control_decoder.sv
// Pure combinational MIPS instruction decoder: instruction word -> control bundle.
// Latency: zero cycles (combinational).
// Backpressure: none; the caller decides whether the result is used.
module control_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Decode opcode/funct into ALU function, operand select, immediate and control bits
    always_comb begin
        ctrl           = '0;
        ctrl.rs        = instr[25:21];
        ctrl.rt        = instr[20:16];
        ctrl.shamt     = instr[10:6];
        ctrl.dest      = instr[20:16];
        ctrl.imm       = {{16{instr[15]}}, instr[15:0]};
        ctrl.uses_rs   = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctrl.dest      = instr[15:11];
                ctrl.reg_write = 1'b1;
                ctrl.uses_rt   = 1'b1;
                ctrl.muxb      = MUXB_REG;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_fn = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_fn = ALU_SUB;
                    FN_AND:          ctrl.alu_fn = ALU_AND;
                    FN_OR:           ctrl.alu_fn = ALU_OR;
                    FN_XOR:          ctrl.alu_fn = ALU_XOR;
                    FN_NOR:          ctrl.alu_fn = ALU_NOR;
                    FN_SLT:          ctrl.alu_fn = ALU_SLT;
                    FN_SLL: begin
                        ctrl.alu_fn  = ALU_SLL;
                        ctrl.muxb    = MUXB_SHAMT;
                        ctrl.uses_rs = 1'b0;
                    end
                    FN_SRL: begin
                        ctrl.alu_fn  = ALU_SRL;
                        ctrl.muxb    = MUXB_SHAMT;
                        ctrl.uses_rs = 1'b0;
                    end
                    FN_SRA: begin
                        ctrl.alu_fn  = ALU_SRA;
                        ctrl.muxb    = MUXB_SHAMT;
                        ctrl.uses_rs = 1'b0;
                    end
                    default: begin
                        ctrl.illegal   = 1'b1;
                        ctrl.reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.alu_fn = ALU_ADD; ctrl.muxb = MUXB_IMM; ctrl.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_fn = ALU_SLT; ctrl.muxb = MUXB_IMM; ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_fn = ALU_AND; ctrl.muxb = MUXB_IMM; ctrl.reg_write = 1'b1;
                ctrl.imm    = {16'h0, instr[15:0]};
            end
            OP_ORI: begin
                ctrl.alu_fn = ALU_OR; ctrl.muxb = MUXB_IMM; ctrl.reg_write = 1'b1;
                ctrl.imm    = {16'h0, instr[15:0]};
            end
            OP_XORI: begin
                ctrl.alu_fn = ALU_XOR; ctrl.muxb = MUXB_IMM; ctrl.reg_write = 1'b1;
                ctrl.imm    = {16'h0, instr[15:0]};
            end
            OP_LUI: begin
                ctrl.alu_fn  = ALU_OR; ctrl.muxb = MUXB_IMM; ctrl.reg_write = 1'b1;
                ctrl.imm     = {instr[15:0], 16'h0};
                ctrl.uses_rs = 1'b0;
            end
            OP_LW: begin
                ctrl.alu_fn   = ALU_ADD; ctrl.muxb = MUXB_IMM;
                ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_fn    = ALU_ADD; ctrl.muxb = MUXB_IMM;
                ctrl.mem_write = 1'b1; ctrl.uses_rt = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_fn = ALU_SUB; ctrl.muxb = MUXB_REG;
                ctrl.branch = BR_BEQ; ctrl.uses_rt = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_fn = ALU_SUB; ctrl.muxb = MUXB_REG;
                ctrl.branch = BR_BNE; ctrl.uses_rt = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        // $0 is hardwired; never request a write to it
        if (ctrl.dest == 5'd0) ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/decode_issue.sv
// ID stage: decodes the fetched word, detects load-use hazards and fills the ID/EX register.
// Latency: one cycle from accept (if_valid & id_ready) to ex_valid.
// Backpressure: id_ready drops on ex_hold, load-use hazard or reset; fetch re-presents the word.
module decode_issue
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_hold,
    output logic [4:0]  rf_rs_addr,
    output logic [4:0]  rf_rt_addr,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_SignExtImm,
    output logic [4:0]  ex_shamt,
    output logic [1:0]  ex_mux_1_flag,
    output logic [3:0]  ex_Alu_function,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [1:0]  ex_branch,
    output logic        illegal
);

    ctrl_t ctrl;
    idex_t ex_q;
    idex_t dec;
    logic  illegal_q;
    logic  hazard;
    logic  accept;

    control_decoder u_dec (
        .instr (if_instr),
        .ctrl  (ctrl)
    );

    assign rf_rs_addr = if_instr[25:21];
    assign rf_rt_addr = if_instr[20:16];

    // Load-use: the load in EX writes a register this instruction really reads
    always_comb begin
        hazard = ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) &
                 ((ctrl.uses_rs & (ex_q.dest == ctrl.rs)) |
                  (ctrl.uses_rt & (ex_q.dest == ctrl.rt)));
    end

    assign id_ready = rst_n & ~ex_hold & ~hazard;
    assign accept   = if_valid & id_ready;

    // Build the ID/EX image of the presented instruction; illegal words may become a bubble
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.pc        = if_pc;
        dec.rs        = ctrl.rs;
        dec.rt        = ctrl.rt;
        dec.dest      = ctrl.dest;
        dec.imm       = ctrl.imm;
        dec.shamt     = ctrl.shamt;
        dec.muxb      = ctrl.muxb;
        dec.alu_fn    = ctrl.alu_fn;
        dec.reg_write = ctrl.reg_write;
        dec.mem_read  = ctrl.mem_read;
        dec.mem_write = ctrl.mem_write;
        dec.branch    = ctrl.branch;
        if (ctrl.illegal && ILLEGAL_AS_NOP) dec = '0;
    end

    // ID/EX register: reset > flush > hold > hazard > accept > bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            // a wrong-path word killed by flush does not report illegal
            illegal_q <= accept & ctrl.illegal & ~flush;
            if (flush)        ex_q <= '0;
            else if (ex_hold) ex_q <= ex_q;
            else if (hazard)  ex_q <= '0;
            else if (accept)  ex_q <= dec;
            else              ex_q <= '0;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign ex_pc           = ex_q.pc;
    assign ex_rs           = ex_q.rs;
    assign ex_rt           = ex_q.rt;
    assign ex_dest         = ex_q.dest;
    assign ex_SignExtImm   = ex_q.imm;
    assign ex_shamt        = ex_q.shamt;
    assign ex_mux_1_flag   = ex_q.muxb;
    assign ex_Alu_function = ex_q.alu_fn;
    assign ex_reg_write    = ex_q.reg_write;
    assign ex_mem_read     = ex_q.mem_read;
    assign ex_mem_write    = ex_q.mem_write;
    assign ex_branch       = ex_q.branch;
    assign illegal         = illegal_q;

endmodule
